// File: rtl/wci_axi_mon_pkg.sv
// Shared definitions for the WCI AXI-Lite protocol monitor: error-bit map,
// response encodings and small helpers used by the top.
package wci_axi_mon_pkg;

  localparam int ERR_W        = 12;
  localparam int ERR_AW_STAB  = 0;
  localparam int ERR_W_STAB   = 1;
  localparam int ERR_B_STAB   = 2;
  localparam int ERR_AR_STAB  = 3;
  localparam int ERR_R_STAB   = 4;
  localparam int ERR_B_ORPHAN = 5;
  localparam int ERR_R_ORPHAN = 6;
  localparam int ERR_WR_OVF   = 7;
  localparam int ERR_RD_OVF   = 8;
  localparam int ERR_WR_TMO   = 9;
  localparam int ERR_RD_TMO   = 10;
  localparam int ERR_RESP     = 11;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  function automatic logic [3:0] lowest_set(input logic [ERR_W-1:0] v);
    lowest_set = '0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

  // Accept and response in the same cycle cancel; the count saturates at lim and 0.
  function automatic logic [3:0] pend_next(input logic [3:0] cnt, input logic inc,
                                           input logic dec, input logic [3:0] lim);
    pend_next = cnt;
    if (inc && !dec && cnt != lim) pend_next = cnt + 4'd1;
    else if (dec && !inc && cnt != 4'd0) pend_next = cnt - 4'd1;
  endfunction

endpackage

// File: rtl/wci_axi_chan_check.sv
// One observed VALID/READY channel: handshake pulse plus stall-stability check
// (VALID must stay high and payload must hold while the previous cycle stalled).
module wci_axi_chan_check #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         link_rst_n,
  input  logic         valid,
  input  logic         ready,
  input  logic [W-1:0] payload,
  output logic         hs,
  output logic         stab_err
);

  logic         stall_q, stall_d;
  logic [W-1:0] payload_q, payload_d;

  always_comb begin
    stall_d   = link_rst_n && valid && !ready;
    payload_d = payload;
    hs        = link_rst_n && valid && ready;
    stab_err  = link_rst_n && stall_q && (!valid || (payload != payload_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      stall_q   <= stall_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/wci_axi_protocol_monitor.sv
// Passive AXI-Lite link observer: sticky violation flags, first-error capture,
// outstanding tracking, response watchdogs and completion counters.
module wci_axi_protocol_monitor
  import wci_axi_mon_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          CNT_W   = 16,
  parameter int          MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ARESETn,
  input  logic                AWVALID,
  input  logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [2:0]          AWPROT,
  input  logic                WVALID,
  input  logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  input  logic                BREADY,
  input  logic [1:0]          BRESP,
  input  logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [2:0]          ARPROT,
  input  logic                RVALID,
  input  logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                clr,
  output logic [ERR_W-1:0]    err,
  output logic                first_err_vld,
  output logic [3:0]          first_err,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [3:0]          wr_out,
  output logic [3:0]          rd_out,
  output logic [ADDR_W-1:0]   last_addr
);

  localparam int             STRB_W = DATA_W / 8;
  localparam int             WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] TMO   = WD_W'(TIMEOUT);
  localparam bit             TMO_EN = (TIMEOUT != 0);
  localparam logic [3:0]     MAX_Q  = 4'(MAX_OUT);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_stab, w_stab, b_stab, ar_stab, r_stab;

  wci_axi_chan_check #(.W(ADDR_W + 3)) u_aw (
    .clk(CLK), .rst(RST), .link_rst_n(ARESETn), .valid(AWVALID), .ready(AWREADY),
    .payload({AWPROT, AWADDR}), .hs(aw_hs), .stab_err(aw_stab));

  wci_axi_chan_check #(.W(DATA_W + STRB_W)) u_w (
    .clk(CLK), .rst(RST), .link_rst_n(ARESETn), .valid(WVALID), .ready(WREADY),
    .payload({WSTRB, WDATA}), .hs(w_hs), .stab_err(w_stab));

  wci_axi_chan_check #(.W(2)) u_b (
    .clk(CLK), .rst(RST), .link_rst_n(ARESETn), .valid(BVALID), .ready(BREADY),
    .payload(BRESP), .hs(b_hs), .stab_err(b_stab));

  wci_axi_chan_check #(.W(ADDR_W + 3)) u_ar (
    .clk(CLK), .rst(RST), .link_rst_n(ARESETn), .valid(ARVALID), .ready(ARREADY),
    .payload({ARPROT, ARADDR}), .hs(ar_hs), .stab_err(ar_stab));

  wci_axi_chan_check #(.W(DATA_W + 2)) u_r (
    .clk(CLK), .rst(RST), .link_rst_n(ARESETn), .valid(RVALID), .ready(RREADY),
    .payload({RRESP, RDATA}), .hs(r_hs), .stab_err(r_stab));

  logic [3:0]        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d, rd_out_q, rd_out_d;
  logic [3:0]        wr_out_c;
  logic [WD_W-1:0]   wwd_q, wwd_d, rwd_q, rwd_d;
  logic [ERR_W-1:0]  err_q, err_d, err_new;
  logic              first_err_vld_q, first_err_vld_d;
  logic [3:0]        first_err_q, first_err_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d, rd_count_q, rd_count_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  always_comb begin
    wr_out_c = (aw_pend_q < w_pend_q) ? aw_pend_q : w_pend_q;

    aw_pend_d = ARESETn ? pend_next(aw_pend_q, aw_hs, b_hs, MAX_Q) : 4'd0;
    w_pend_d  = ARESETn ? pend_next(w_pend_q, w_hs, b_hs, MAX_Q) : 4'd0;
    rd_out_d  = ARESETn ? pend_next(rd_out_q, ar_hs, r_hs, MAX_Q) : 4'd0;

    // Watchdogs run only while something is outstanding and park at TIMEOUT.
    wwd_d = '0;
    if (ARESETn && !b_hs && wr_out_c != 4'd0)
      wwd_d = (wwd_q == TMO) ? wwd_q : wwd_q + WD_W'(1);
    rwd_d = '0;
    if (ARESETn && !r_hs && rd_out_q != 4'd0)
      rwd_d = (rwd_q == TMO) ? rwd_q : rwd_q + WD_W'(1);

    err_new               = '0;
    err_new[ERR_AW_STAB]  = aw_stab;
    err_new[ERR_W_STAB]   = w_stab;
    err_new[ERR_B_STAB]   = b_stab;
    err_new[ERR_AR_STAB]  = ar_stab;
    err_new[ERR_R_STAB]   = r_stab;
    err_new[ERR_B_ORPHAN] = b_hs && (aw_pend_q == 4'd0 || w_pend_q == 4'd0);
    err_new[ERR_R_ORPHAN] = r_hs && (rd_out_q == 4'd0);
    err_new[ERR_WR_OVF]   = (aw_hs || w_hs) && (wr_out_c == MAX_Q);
    err_new[ERR_RD_OVF]   = ar_hs && (rd_out_q == MAX_Q);
    err_new[ERR_WR_TMO]   = TMO_EN && (wwd_d == TMO) && (wwd_q != TMO);
    err_new[ERR_RD_TMO]   = TMO_EN && (rwd_d == TMO) && (rwd_q != TMO);
    err_new[ERR_RESP]     = (b_hs && BRESP != RESP_OKAY) || (r_hs && RRESP != RESP_OKAY);

    err_d           = err_q | err_new;
    first_err_vld_d = first_err_vld_q;
    first_err_d     = first_err_q;
    if (!first_err_vld_q && err_new != '0) begin
      first_err_vld_d = 1'b1;
      first_err_d     = lowest_set(err_new);
    end
    wr_count_d = b_hs ? wr_count_q + CNT_W'(1) : wr_count_q;
    rd_count_d = r_hs ? rd_count_q + CNT_W'(1) : rd_count_q;

    // clr wins over anything flagged or counted in the same cycle.
    if (clr) begin
      err_d           = '0;
      first_err_vld_d = 1'b0;
      first_err_d     = '0;
      wr_count_d      = '0;
      rd_count_d      = '0;
    end

    last_addr_d = last_addr_q;
    if (aw_hs)      last_addr_d = AWADDR;
    else if (ar_hs) last_addr_d = ARADDR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aw_pend_q       <= '0;
      w_pend_q        <= '0;
      rd_out_q        <= '0;
      wwd_q           <= '0;
      rwd_q           <= '0;
      err_q           <= '0;
      first_err_vld_q <= 1'b0;
      first_err_q     <= '0;
      wr_count_q      <= '0;
      rd_count_q      <= '0;
      last_addr_q     <= '0;
    end else begin
      aw_pend_q       <= aw_pend_d;
      w_pend_q        <= w_pend_d;
      rd_out_q        <= rd_out_d;
      wwd_q           <= wwd_d;
      rwd_q           <= rwd_d;
      err_q           <= err_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_q     <= first_err_d;
      wr_count_q      <= wr_count_d;
      rd_count_q      <= rd_count_d;
      last_addr_q     <= last_addr_d;
    end
  end

  assign err           = err_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err     = first_err_q;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;
  assign wr_out        = wr_out_c;
  assign rd_out        = rd_out_q;
  assign last_addr     = last_addr_q;

endmodule

// File: tb/tb_wci_axi_protocol_monitor.sv
// Bench for wci_axi_protocol_monitor: directed scenarios then random link traffic,
// each cycle's expected outputs queued by a rule-level model and checked by a monitor.
module tb_wci_axi_protocol_monitor;

  localparam int MAX = 4;
  localparam int TMO = 8;

  logic        CLK, RST, ARESETn, clr;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [11:0] err;
  logic        first_err_vld;
  logic [3:0]  first_err, wr_out, rd_out;
  logic [15:0] wr_count, rd_count;
  logic [31:0] last_addr;

  wci_axi_protocol_monitor #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .MAX_OUT(MAX), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST(RST), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .clr(clr), .err(err), .first_err_vld(first_err_vld), .first_err(first_err),
    .wr_count(wr_count), .rd_count(rd_count), .wr_out(wr_out), .rd_out(rd_out),
    .last_addr(last_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] err;
    logic        fvld;
    logic [3:0]  ferr;
    logic [15:0] wrc;
    logic [15:0] rdc;
    logic [3:0]  wro;
    logic [3:0]  rdo;
    logic [31:0] la;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: outstanding transactions as plain integers, per-channel
  // record of the beat being offered while stalled.
  int          m_aw, m_w, m_rd, m_wwd, m_rwd;
  logic [11:0] m_err;
  logic        m_fvld;
  logic [3:0]  m_ferr;
  logic [15:0] m_wrc, m_rdc;
  logic [31:0] m_la;
  bit          stalled[5];
  logic [63:0] held[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit vld(int ch);
    case (ch)
      0: return AWVALID;
      1: return WVALID;
      2: return BVALID;
      3: return ARVALID;
      default: return RVALID;
    endcase
  endfunction

  function automatic bit rdy(int ch);
    case (ch)
      0: return AWREADY;
      1: return WREADY;
      2: return BREADY;
      3: return ARREADY;
      default: return RREADY;
    endcase
  endfunction

  function automatic logic [63:0] pay(int ch);
    case (ch)
      0: return 64'({AWPROT, AWADDR});
      1: return 64'({WSTRB, WDATA});
      2: return 64'(BRESP);
      3: return 64'({ARPROT, ARADDR});
      default: return 64'({RRESP, RDATA});
    endcase
  endfunction

  function automatic int outstanding(int c, bit accept, bit resp);
    if (accept && !resp) return (c + 1 > MAX) ? MAX : c + 1;
    if (resp && !accept) return (c > 0) ? c - 1 : 0;
    return c;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_aw = 0; m_w = 0; m_rd = 0; m_wwd = 0; m_rwd = 0;
    m_err = '0; m_fvld = 1'b0; m_ferr = '0; m_wrc = '0; m_rdc = '0; m_la = '0;
    for (int c = 0; c < 5; c++) begin
      stalled[c] = 1'b0;
      held[c]    = '0;
    end
  endtask

  task automatic model_step();
    logic [11:0] nw;
    bit          hs[5];
    int          wr_old, rd_old, prev;
    if (RST) begin
      model_reset();
      return;
    end
    nw = '0;
    if (ARESETn) begin
      for (int c = 0; c < 5; c++) begin
        hs[c] = vld(c) && rdy(c);
        if (stalled[c] && (!vld(c) || pay(c) != held[c])) nw[c] = 1'b1;
      end
      wr_old = imin(m_aw, m_w);
      rd_old = m_rd;
      if (hs[2] && (m_aw == 0 || m_w == 0)) nw[5] = 1'b1;
      if (hs[4] && rd_old == 0) nw[6] = 1'b1;
      if ((hs[0] || hs[1]) && wr_old == MAX) nw[7] = 1'b1;
      if (hs[3] && rd_old == MAX) nw[8] = 1'b1;
      if ((hs[2] && BRESP != 2'b00) || (hs[4] && RRESP != 2'b00)) nw[11] = 1'b1;
      prev  = m_wwd;
      m_wwd = hs[2] ? 0 : (wr_old > 0) ? imin(m_wwd + 1, TMO) : 0;
      if (m_wwd == TMO && prev != TMO) nw[9] = 1'b1;
      prev  = m_rwd;
      m_rwd = hs[4] ? 0 : (rd_old > 0) ? imin(m_rwd + 1, TMO) : 0;
      if (m_rwd == TMO && prev != TMO) nw[10] = 1'b1;
      m_aw = outstanding(m_aw, hs[0], hs[2]);
      m_w  = outstanding(m_w, hs[1], hs[2]);
      m_rd = outstanding(m_rd, hs[3], hs[4]);
      if (hs[2]) m_wrc = m_wrc + 16'd1;
      if (hs[4]) m_rdc = m_rdc + 16'd1;
      if (hs[0]) m_la = AWADDR;
      else if (hs[3]) m_la = ARADDR;
      for (int c = 0; c < 5; c++) begin
        stalled[c] = vld(c) && !rdy(c);
        held[c]    = pay(c);
      end
    end else begin
      m_aw = 0; m_w = 0; m_rd = 0; m_wwd = 0; m_rwd = 0;
      for (int c = 0; c < 5; c++) stalled[c] = 1'b0;
    end
    if (clr) begin
      m_err = '0; m_fvld = 1'b0; m_ferr = '0; m_wrc = '0; m_rdc = '0;
    end else begin
      m_err = m_err | nw;
      if (!m_fvld && nw != '0) begin
        m_fvld = 1'b1;
        for (int b = 11; b >= 0; b--) if (nw[b]) m_ferr = 4'(b);
      end
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.err = m_err; e.fvld = m_fvld; e.ferr = m_ferr; e.wrc = m_wrc; e.rdc = m_rdc;
    e.wro = 4'(imin(m_aw, m_w)); e.rdo = 4'(m_rd); e.la = m_la;
    return e;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    model_step();
    sb_q.push_back(cur_exp());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; BVALID = 0; BREADY = 0;
    ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; clr = 0;
    BRESP = 2'b00; RRESP = 2'b00;
  endtask

  task automatic assert_rst();
    RST = 1'b1;
    #1;
    model_reset();
    sb_q[sb_q.size() - 1] = cur_exp();
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_wr_out", 64'(wr_out), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_last_addr", 64'(last_addr), 64'd0);
  endtask

  // Monitor: outputs compared mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("err", 64'(err), 64'(e.err));
        chk("first_err_vld", 64'(first_err_vld), 64'(e.fvld));
        chk("first_err", 64'(first_err), 64'(e.ferr));
        chk("wr_count", 64'(wr_count), 64'(e.wrc));
        chk("rd_count", 64'(rd_count), 64'(e.rdc));
        chk("wr_out", 64'(wr_out), 64'(e.wro));
        chk("rd_out", 64'(rd_out), 64'(e.rdo));
        chk("last_addr", 64'(last_addr), 64'(e.la));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish before 100000");
    $fatal(1, "bench timeout");
  end

  initial begin
    RST = 1'b1; ARESETn = 1'b1;
    AWADDR = '0; AWPROT = '0; WDATA = '0; WSTRB = 4'hf; ARADDR = '0; ARPROT = '0; RDATA = '0;
    idle();
    model_reset();
    steps(3);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_last_addr", 64'(last_addr), 64'd0);
    RST = 1'b0;
    steps(2);

    // Clean write then clean read.
    AWVALID = 1; AWREADY = 1; AWADDR = 32'h1000; WVALID = 1; WREADY = 1; WDATA = 32'hcafe0001;
    step(); idle(); step();
    BVALID = 1; BREADY = 1; step(); idle(); steps(3);
    ARVALID = 1; ARREADY = 1; ARADDR = 32'h2000; step(); idle(); steps(2);
    RVALID = 1; RREADY = 1; RDATA = 32'h12345678; step(); idle(); step();
    chk("t1_wr_count", 64'(wr_count), 64'd1);
    chk("t1_rd_count", 64'(rd_count), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_last_addr", 64'(last_addr), 64'h2000);

    // AWADDR changes while stalled.
    AWVALID = 1; AWREADY = 0; AWADDR = 32'h100; step();
    AWADDR = 32'h104; step();
    chk("t2_err0", 64'(err[0]), 64'd1);
    chk("t2_first_err", 64'(first_err), 64'd0);
    chk("t2_first_vld", 64'(first_err_vld), 64'd1);
    AWREADY = 1; step(); idle();
    WVALID = 1; WREADY = 1; step(); idle();
    BVALID = 1; BREADY = 1; step(); idle();
    clr = 1; step(); clr = 0;

    // B in the same cycle as the completing AW+W.
    AWVALID = 1; AWREADY = 1; AWADDR = 32'h200; WVALID = 1; WREADY = 1;
    BVALID = 1; BREADY = 1; step(); idle();
    chk("t3_err5", 64'(err[5]), 64'd1);
    step();
    chk("t3_wr_out", 64'(wr_out), 64'd0);
    clr = 1; step(); clr = 0;

    // Read outstanding overflow then drain.
    for (int i = 0; i < 5; i++) begin
      ARVALID = 1; ARREADY = 1; ARADDR = 32'h3000 + 32'(i * 4); step();
    end
    idle();
    chk("t4_err8", 64'(err[8]), 64'd1);
    chk("t4_rd_out_full", 64'(rd_out), 64'd4);
    RVALID = 1; RREADY = 1; steps(4); idle();
    chk("t4_rd_out_empty", 64'(rd_out), 64'd0);
    chk("t4_rd_count", 64'(rd_count), 64'd4);
    clr = 1; step(); clr = 0;

    // Read watchdog fires exactly TMO cycles after accept.
    ARVALID = 1; ARREADY = 1; ARADDR = 32'h4000; step(); idle();
    steps(TMO - 1);
    chk("t5_err10_early", 64'(err[10]), 64'd0);
    step();
    chk("t5_err10", 64'(err[10]), 64'd1);
    steps(3);
    RVALID = 1; RREADY = 1; step(); idle();
    clr = 1; step(); clr = 0;

    // Error response, clear, then async reset mid-write.
    ARVALID = 1; ARREADY = 1; ARADDR = 32'h5000; step(); idle();
    RVALID = 1; RREADY = 1; RRESP = 2'b10; step(); idle();
    chk("t6_err11", 64'(err[11]), 64'd1);
    clr = 1; step(); clr = 0;
    chk("t6_clr_err", 64'(err), 64'd0);
    chk("t6_clr_fvld", 64'(first_err_vld), 64'd0);
    chk("t6_clr_rd_count", 64'(rd_count), 64'd0);
    AWVALID = 1; AWREADY = 1; AWADDR = 32'h6000; WVALID = 1; WREADY = 1; step(); idle();
    chk("t6_wr_out", 64'(wr_out), 64'd1);
    assert_rst();
    steps(2);
    RST = 1'b0;
    step();

    // Random traffic, including link resets, clears and protocol abuse.
    for (int n = 0; n < 400; n++) begin
      AWVALID = 1'($urandom_range(0, 1)); AWREADY = 1'($urandom_range(0, 1));
      WVALID  = 1'($urandom_range(0, 1)); WREADY  = 1'($urandom_range(0, 1));
      BVALID  = ($urandom_range(0, 2) == 0); BREADY = 1'($urandom_range(0, 1));
      ARVALID = 1'($urandom_range(0, 1)); ARREADY = 1'($urandom_range(0, 1));
      RVALID  = ($urandom_range(0, 2) == 0); RREADY = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) AWADDR = 32'($urandom_range(0, 3)) << 2;
      if ($urandom_range(0, 7) == 0) AWPROT = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) WDATA = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) WSTRB = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ARADDR = 32'h800 + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 7) == 0) ARPROT = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) RDATA = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) BRESP = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 3) == 0) RRESP = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      clr     = ($urandom_range(0, 15) == 0);
      ARESETn = ($urandom_range(0, 24) != 0);
      step();
      if (n == 200) begin
        assert_rst();
        steps(2);
        RST = 1'b0;
      end
    end
    idle();
    ARESETn = 1'b1;
    steps(2);
    @(negedge CLK);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
